// File: rtl/router_pkt_reader_pkg.sv
// Shared types and header field layout for the router destination-side packet reader.
package router_pkt_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HDR,
        ST_BODY,
        ST_DONE
    } rd_state_e;

    localparam int HDR_LEN_MSB       = 7;
    localparam int HDR_LEN_LSB       = 2;
    localparam int HDR_ADDR_W        = 2;
    localparam int SOFT_RESET_WINDOW = 30;

    localparam int LEN_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;
    localparam int REM_W = LEN_W + 1;
    localparam int DLY_W = $clog2(SOFT_RESET_WINDOW);

endpackage

// File: rtl/router_parity_acc.sv
// Bytewise XOR accumulator: clear, seed with the header, fold payload bytes,
// and compare against the received parity byte.
module router_parity_acc (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear_i,
    input  logic       seed_i,
    input  logic       fold_i,
    input  logic [7:0] byte_i,
    output logic       mismatch_o
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (seed_i) begin
            acc_d = byte_i;
        end else if (fold_i) begin
            acc_d = acc_q ^ byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign mismatch_o = (acc_q != byte_i);

endmodule

// File: rtl/router_pkt_reader.sv
// Router output-port packet reader: drains the port FIFO and splits header, payload, parity.
// Define ROUTER_PARITY_CHECK_EN to build the parity checker; otherwise parity_err is tied to 0.
module router_pkt_reader
    import router_pkt_reader_pkg::*;
#(
    parameter int READ_DELAY = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid_out,
    input  logic [7:0]            data_out,
    input  logic                  soft_reset_in,
    output logic                  read_enb,
    output logic                  byte_valid,
    output logic [7:0]            byte_data,
    output logic [HDR_ADDR_W-1:0] pkt_addr,
    output logic [LEN_W-1:0]      pkt_len,
    output logic                  pkt_done,
    output logic                  parity_err
);

    // First read must land inside the router's soft-reset window.
    if (READ_DELAY < 0 || READ_DELAY > SOFT_RESET_WINDOW - 2) begin : g_bad_read_delay
        $error("router_pkt_reader: READ_DELAY out of range 0..28");
    end

    rd_state_e             state_q, state_d;
    logic [DLY_W-1:0]      dly_q, dly_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  read_enb_q, read_enb_d;
    logic                  byte_valid_q, byte_valid_d;
    logic [7:0]            byte_data_q, byte_data_d;
    logic [HDR_ADDR_W-1:0] pkt_addr_q, pkt_addr_d;
    logic [LEN_W-1:0]      pkt_len_q, pkt_len_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  parity_err_q, parity_err_d;

    logic rd_fire;
    logic par_mismatch;

    assign rd_fire = read_enb_q & valid_out;

`ifdef ROUTER_PARITY_CHECK_EN
    logic acc_clear;
    logic acc_seed;
    logic acc_fold;

    assign acc_clear = soft_reset_in;
    assign acc_seed  = (state_q == ST_HDR) && rd_pend_q && !soft_reset_in;
    assign acc_fold  = (state_q == ST_BODY) && rd_pend_q && (rem_q > REM_W'(1)) && !soft_reset_in;

    router_parity_acc u_parity_acc (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (acc_clear),
        .seed_i     (acc_seed),
        .fold_i     (acc_fold),
        .byte_i     (data_out),
        .mismatch_o (par_mismatch)
    );
`else
    assign par_mismatch = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        rem_d        = rem_q;
        rd_pend_d    = rd_fire;
        read_enb_d   = 1'b0;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        pkt_addr_d   = pkt_addr_q;
        pkt_len_d    = pkt_len_q;
        pkt_done_d   = 1'b0;
        parity_err_d = parity_err_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_out) begin
                    dly_d   = DLY_W'(READ_DELAY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dly_q == '0) begin
                    read_enb_d = 1'b1;
                    state_d    = ST_HDR;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_HDR: begin
                // Exactly one header read: drop the request on the accepting edge.
                read_enb_d = !rd_fire;
                if (rd_pend_q) begin
                    pkt_addr_d   = data_out[HDR_ADDR_W-1:0];
                    pkt_len_d    = data_out[HDR_LEN_MSB:HDR_LEN_LSB];
                    rem_d        = REM_W'(data_out[HDR_LEN_MSB:HDR_LEN_LSB]) + REM_W'(1);
                    parity_err_d = 1'b0;
                    state_d      = ST_BODY;
                end
            end
            ST_BODY: begin
                if (rd_pend_q) begin
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        parity_err_d = par_mismatch;
                        pkt_done_d   = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = data_out;
                    end
                end
                // Only request another byte if the one in flight still leaves some owed.
                read_enb_d = (REM_W'(rd_pend_d) < rem_d);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (soft_reset_in) begin
            state_d      = ST_IDLE;
            dly_d        = '0;
            rem_d        = '0;
            rd_pend_d    = 1'b0;
            read_enb_d   = 1'b0;
            byte_valid_d = 1'b0;
            byte_data_d  = byte_data_q;
            pkt_addr_d   = pkt_addr_q;
            pkt_len_d    = pkt_len_q;
            pkt_done_d   = 1'b0;
            parity_err_d = parity_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dly_q        <= '0;
            rem_q        <= '0;
            rd_pend_q    <= 1'b0;
            read_enb_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            pkt_addr_q   <= '0;
            pkt_len_q    <= '0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            rem_q        <= rem_d;
            rd_pend_q    <= rd_pend_d;
            read_enb_q   <= read_enb_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            pkt_addr_q   <= pkt_addr_d;
            pkt_len_q    <= pkt_len_d;
            pkt_done_q   <= pkt_done_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign read_enb   = read_enb_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign pkt_addr   = pkt_addr_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_done   = pkt_done_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_router_pkt_reader.sv
// Self-checking bench for router_pkt_reader: FIFO model, payload and packet scoreboards.
module tb_router_pkt_reader;

    localparam int READ_DELAY = 4;

`ifdef ROUTER_PARITY_CHECK_EN
    localparam bit BAD_ERR = 1'b1;
`else
    localparam bit BAD_ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       valid_out = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic       soft_reset_in = 1'b0;
    logic       read_enb;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic [1:0] pkt_addr;
    logic [5:0] pkt_len;
    logic       pkt_done;
    logic       parity_err;

    always #5 clk = ~clk;

    router_pkt_reader #(.READ_DELAY(READ_DELAY)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .valid_out     (valid_out),
        .data_out      (data_out),
        .soft_reset_in (soft_reset_in),
        .read_enb      (read_enb),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .pkt_addr      (pkt_addr),
        .pkt_len       (pkt_len),
        .pkt_done      (pkt_done),
        .parity_err    (parity_err)
    );

    // scoreboards: payload bytes, and packed {nreads, err, len, addr} per packet
    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [16:0] exp_pkt_q[$];

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int rd_count = 0;
    int bytes_seen = 0;
    int done_cnt = 0;

    bit         fire_prev = 1'b0;
    logic [7:0] held = 8'h00;
    bit         stall_mode = 1'b0;
    bit         stall_done = 1'b0;
    int         stall_left = 0;
    bit         abort_mode = 1'b0;
    bit         abort_done = 1'b0;
    bit         timing_arm = 1'b0;
    int         valid_rise_cyc = -1;
    int         re_rise_cyc = -1;
    bit         prev_valid = 1'b0;
    bit         prev_re = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] pk(input int n, input bit err, input int len, input int addr);
        return {8'(n), err, 6'(len), 2'(addr)};
    endfunction

    // monitor + FIFO driver, all on the falling edge
    always @(negedge clk) begin
        logic [7:0]  eb;
        logic [16:0] ep;
        logic [16:0] act;
        if (reset_n) begin
            if (byte_valid === 1'b1) begin
                bytes_seen++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL byte_unexpected: got byte %02h, expected none", byte_data);
                end else begin
                    eb = exp_q.pop_front();
                    if (byte_data !== eb) begin
                        fails++;
                        $display("FAIL byte_data: got %02h, expected %02h", byte_data, eb);
                    end
                end
            end
            if (pkt_done === 1'b1) begin
                act = {8'(rd_count), parity_err, pkt_len, pkt_addr};
                done_cnt++;
                tests_run++;
                if (exp_pkt_q.size() == 0) begin
                    fails++;
                    $display("FAIL pkt_unexpected: got {nrd,err,len,addr}=%h, expected none", act);
                end else begin
                    ep = exp_pkt_q.pop_front();
                    if (act !== ep) begin
                        fails++;
                        $display("FAIL pkt_done: got {nrd,err,len,addr}=%h, expected %h", act, ep);
                    end
                end
                rd_count = 0;
            end
        end

        if (abort_mode && !abort_done && bytes_seen == 1) begin
            soft_reset_in = 1'b1;
            fifo_q.delete();
            abort_done = 1'b1;
        end else begin
            soft_reset_in = 1'b0;
        end

        if (stall_mode && !stall_done && bytes_seen == 2) begin
            stall_left = 5;
            stall_done = 1'b1;
        end

        if (fire_prev) data_out = held;
        else           data_out = 8'($urandom);
        valid_out = (fifo_q.size() > 0) && (stall_left == 0);
        if (stall_left > 0) stall_left--;
        fire_prev = (read_enb === 1'b1) && valid_out;
        if (fire_prev) begin
            held = fifo_q.pop_front();
            rd_count++;
        end

        if (timing_arm && valid_out && !prev_valid) valid_rise_cyc = cyc;
        if (timing_arm && (read_enb === 1'b1) && !prev_re && re_rise_cyc < 0) re_rise_cyc = cyc;
        prev_valid = valid_out;
        prev_re    = (read_enb === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 400 && done_cnt < target; i++) tick(1);
        tests_run++;
        if (done_cnt < target) begin
            fails++;
            $display("FAIL %s_timeout: got %0d packets done, expected %0d", name, done_cnt, target);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        fifo_q.push_back(8'hA5);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            tests_run++;
            if ({read_enb, byte_valid, pkt_done, parity_err, byte_data, pkt_addr, pkt_len} !== 20'h0) begin
                fails++;
                $display("FAIL reset_outputs: got %h, expected 0",
                         {read_enb, byte_valid, pkt_done, parity_err, byte_data, pkt_addr, pkt_len});
            end
        end
        fifo_q.delete();
        tick(1);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_good();
        rd_count = 0;
        valid_rise_cyc = -1;
        re_rise_cyc = -1;
        timing_arm = 1'b1;
        fifo_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_pkt_q.push_back(pk(5, 1'b0, 3, 1));
        wait_done(done_cnt + 1, "good");
        timing_arm = 1'b0;
        tests_run++;
        if (valid_rise_cyc < 0 || re_rise_cyc - valid_rise_cyc !== READ_DELAY + 2) begin
            fails++;
            $display("FAIL first_read_delay: got %0d edges, expected %0d",
                     re_rise_cyc - valid_rise_cyc - 1, READ_DELAY + 1);
        end
        tick(3);
    endtask

    task automatic test_back_to_back();
        int target;
        target = done_cnt + 2;
        rd_count = 0;
        fifo_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C, 8'h02, 8'h02};
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_pkt_q.push_back(pk(5, BAD_ERR, 3, 1));
        exp_pkt_q.push_back(pk(2, 1'b0, 0, 2));
        wait_done(target, "back_to_back");
        tick(3);
    endtask

    task automatic test_underflow();
        rd_count = 0;
        bytes_seen = 0;
        stall_done = 1'b0;
        stall_mode = 1'b1;
        fifo_q = '{8'h15, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h14};
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        exp_pkt_q.push_back(pk(7, 1'b0, 5, 1));
        wait_done(done_cnt + 1, "underflow");
        stall_mode = 1'b0;
        tests_run++;
        if (stall_done !== 1'b1) begin
            fails++;
            $display("FAIL underflow_stall: got stall_done=%0d, expected 1", stall_done);
        end
        tick(3);
    endtask

    task automatic test_abort_recover();
        int d0;
        bytes_seen = 0;
        abort_done = 1'b0;
        abort_mode = 1'b1;
        fifo_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        exp_q.push_back(8'h11);
        for (int i = 0; i < 200 && !abort_done; i++) tick(1);
        tests_run++;
        if (!abort_done) begin
            fails++;
            $display("FAIL abort_timeout: got no payload byte, expected one");
        end
        abort_mode = 1'b0;
        d0 = done_cnt;
        tests_run++;
        if ({read_enb, byte_valid, pkt_done} !== 3'b000) begin
            fails++;
            $display("FAIL abort_outputs: got re/bv/done=%b, expected 000", {read_enb, byte_valid, pkt_done});
        end
        tests_run++;
        if ({pkt_addr, pkt_len} !== {2'd1, 6'd3}) begin
            fails++;
            $display("FAIL abort_hold_hdr: got addr=%0d len=%0d, expected addr=1 len=3", pkt_addr, pkt_len);
        end
        tick(10);
        tests_run++;
        if (done_cnt !== d0 || read_enb !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: got done_cnt=%0d read_enb=%b, expected %0d 0", done_cnt, read_enb, d0);
        end
        rd_count = 0;
        fifo_q = '{8'h05, 8'hAA, 8'hAF};
        exp_q.push_back(8'hAA);
        exp_pkt_q.push_back(pk(3, 1'b0, 1, 1));
        wait_done(done_cnt + 1, "recover");
        tick(5);
    endtask

    initial begin
        test_reset();
        test_good();
        test_back_to_back();
        test_underflow();
        test_abort_recover();
        tests_run++;
        if (exp_q.size() != 0 || exp_pkt_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d bytes %0d packets left, expected 0 0",
                     exp_q.size(), exp_pkt_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
